// File: rtl/nms_pkg.sv
// rtl/nms_pkg.sv - shared types and constants for the non-maximum suppression stage
//
// Contents:
//   mag_t       signed 11-bit gradient magnitude
//   dir_t       quantized gradient direction (0, 45, 90, 135 degrees)
//   WIN_PIXELS  pixels per 3x3 window
//   CENTRE_IDX  raster index of the window centre
//   HIST_DEPTH  default depth of the result history
package nms_pkg;

  typedef logic signed [10:0] mag_t;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_t;

  localparam int WIN_PIXELS = 9;
  localparam int CENTRE_IDX = 4;
  localparam int HIST_DEPTH = 12;

endpackage

// File: rtl/nms_compare.sv
// rtl/nms_compare.sv - combinational keep/suppress decision for one 3x3 window
//
// Ports:
//   centre  in  magnitude of the window centre
//   dir     in  quantized gradient direction of the centre
//   win     in  the 9 window magnitudes in raster order
//   result  out centre magnitude if it is a local maximum along dir, else 0
module nms_compare
  import nms_pkg::*;
(
  input  mag_t centre,
  input  dir_t dir,
  input  mag_t win [WIN_PIXELS],
  output mag_t result
);

  mag_t nbr_a;
  mag_t nbr_b;

  // The neighbour pair lies across the edge, i.e. along the gradient.
  always_comb begin
    nbr_a = '0;
    nbr_b = '0;
    unique case (dir)
      DIR_0:   begin nbr_a = win[3]; nbr_b = win[5]; end
      DIR_45:  begin nbr_a = win[2]; nbr_b = win[6]; end
      DIR_90:  begin nbr_a = win[1]; nbr_b = win[7]; end
      DIR_135: begin nbr_a = win[0]; nbr_b = win[8]; end
      default: begin nbr_a = '0;     nbr_b = '0;     end
    endcase
  end

  // Ties keep the centre; a negative centre is never an edge.
  always_comb begin
    result = '0;
    if (!centre[10] && (centre >= nbr_a) && (centre >= nbr_b)) begin
      result = centre;
    end
  end

endmodule

// File: rtl/non_max_suppression.sv
// rtl/non_max_suppression.sv - Canny non-maximum suppression with a 12-deep result history
//
// Pixels of each 3x3 window arrive in raster order (k = 0..8), one per
// pixel_valid cycle. When k = 8 is accepted the centre is kept or
// suppressed and the result is shifted into processed_pixels[0].
//
// Ports:
//   clk                       in  rising-edge clock
//   rst_n                     in  asynchronous active-low reset
//   pixel_valid               in  qualifies the current pixel pair
//   Gradiant_Magnitude_Pixel  in  signed 11-bit magnitude of window pixel k
//   Direction_Pixel           in  2-bit direction of window pixel k
//   processed_pixels          out result history, index 0 newest
//   result_valid              out one-cycle pulse after each history shift
//
// Optional feature: define NMS_LOW_THRESH_EN to force kept centres below
// LOW_THRESH to 0.
module non_max_suppression
  import nms_pkg::mag_t;
  import nms_pkg::dir_t;
  import nms_pkg::WIN_PIXELS;
  import nms_pkg::CENTRE_IDX;
#(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int WINDOW_SIZE = 3,
  parameter int HIST_DEPTH  = 12,
  parameter int LOW_THRESH  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pixel_valid,
  input  logic signed [10:0]       Gradiant_Magnitude_Pixel,
  input  logic signed [1:0]        Direction_Pixel,
  output logic signed [10:0]       processed_pixels [0:HIST_DEPTH-1],
  output logic                     result_valid
);

  if (WINDOW_SIZE != 3 || IMG_WIDTH < 1 || IMG_HEIGHT < 1 || HIST_DEPTH < 1 ||
      LOW_THRESH > 1023 || LOW_THRESH < -1024) begin : g_bad_cfg
    $error("non_max_suppression: unsupported configuration");
  end

  localparam int LAST_IDX = WIN_PIXELS - 1;

  logic [3:0] cnt_q, cnt_d;
  mag_t       win_mag_q [LAST_IDX];
  mag_t       win_mag_d [LAST_IDX];
  dir_t       dir_q, dir_d;
  mag_t       hist_q [HIST_DEPTH];
  mag_t       hist_d [HIST_DEPTH];
  logic       valid_q, valid_d;

  mag_t       win_all [WIN_PIXELS];
  mag_t       cmp_res;
  mag_t       kept;

  // Stored pixels k = 0..7 plus the live pixel as k = 8.
  always_comb begin
    for (int i = 0; i < LAST_IDX; i++) begin
      win_all[i] = win_mag_q[i];
    end
    win_all[LAST_IDX] = Gradiant_Magnitude_Pixel;
  end

  nms_compare u_compare (
    .centre (win_mag_q[CENTRE_IDX]),
    .dir    (dir_q),
    .win    (win_all),
    .result (cmp_res)
  );

`ifdef NMS_LOW_THRESH_EN
  assign kept = (cmp_res < mag_t'(LOW_THRESH)) ? '0 : cmp_res;
`else
  assign kept = cmp_res;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    win_mag_d = win_mag_q;
    dir_d     = dir_q;
    hist_d    = hist_q;
    valid_d   = 1'b0;
    if (pixel_valid) begin
      if (cnt_q == 4'(LAST_IDX)) begin
        cnt_d   = '0;
        valid_d = 1'b1;
        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
          hist_d[i] = hist_q[i-1];
        end
        hist_d[0] = kept;
      end else begin
        win_mag_d[cnt_q[2:0]] = Gradiant_Magnitude_Pixel;
        if (cnt_q == 4'(CENTRE_IDX)) begin
          dir_d = dir_t'(Direction_Pixel);
        end
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dir_q   <= dir_t'(2'd0);
      valid_q <= 1'b0;
      for (int i = 0; i < LAST_IDX; i++) begin
        win_mag_q[i] <= '0;
      end
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      win_mag_q <= win_mag_d;
      hist_q    <= hist_d;
    end
  end

  always_comb begin
    for (int i = 0; i < HIST_DEPTH; i++) begin
      processed_pixels[i] = hist_q[i];
    end
  end

  assign result_valid = valid_q;

endmodule

// File: tb/tb_non_max_suppression.sv
// tb/tb_non_max_suppression.sv - scoreboard bench for non_max_suppression
module tb_non_max_suppression;

  typedef logic signed [10:0] m_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pixel_valid;
  logic signed [10:0] gmag;
  logic signed [1:0]  gdir;
  logic signed [10:0] pp [0:11];
  logic              result_valid;

  always #5 clk = ~clk;

  non_max_suppression #(.LOW_THRESH(20)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .pixel_valid              (pixel_valid),
    .Gradiant_Magnitude_Pixel (gmag),
    .Direction_Pixel          (gdir),
    .processed_pixels         (pp),
    .result_valid             (result_valid)
  );

  m_t exp_q [$];
  m_t model [0:11];
  m_t win [9];
  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_pulse = 0;

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_hist(input string name);
    int bad;
    bad = -1;
    for (int i = 11; i >= 0; i--) if (pp[i] !== model[i]) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: entry %0d got %0d expected %0d", name, bad, pp[bad], model[bad]);
    end
  endtask

  // Monitor: pops an expected result on every result_valid pulse and
  // tracks the full history it implies.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (result_valid) begin
        n_pulse++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d expected no result", pp[0]);
        end else begin
          m_t e;
          e = exp_q.pop_front();
          for (int i = 11; i > 0; i--) model[i] = model[i-1];
          model[0] = e;
          check("entry0", int'(pp[0]), int'(e));
          check_hist("history_after_shift");
        end
      end else begin
        check_hist("history_hold");
      end
    end
  end

  task automatic fill(input m_t v);
    for (int i = 0; i < 9; i++) win[i] = v;
  endtask

  // Drives one window; centre direction d, other pixels carry a decoy
  // direction. Optional gap of gap_len invalid cycles after pixel gap_after.
  task automatic send(input logic [1:0] d, input int gap_after, input int gap_len, input m_t e);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      pixel_valid = 1'b1;
      gmag = win[k];
      gdir = (k == 4) ? d : ~d;
      if (k == 8) begin
        exp_q.push_back(e);
        n_push++;
      end
      if (k == gap_after && k < 8) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          pixel_valid = 1'b0;
          gmag = 11'sd999;
          gdir = ~d;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      gmag = 11'sd0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result_valid", int'(result_valid), 0);
    check_hist("reset_history");
    rst_n = 1'b1;
  endtask

  initial begin
    int p0;
    int wait_cnt;
    gmag = '0;
    gdir = '0;
    pixel_valid = 1'b0;
    rst_n = 1'b1;
    #2;
    do_reset();

    // Horizontal keep
    fill(11'sd200); win[3] = 11'sd50; win[4] = 11'sd100; win[5] = 11'sd99;
    send(2'b00, -1, 0, 11'sd100);
    // Vertical suppress, back-to-back
    fill(11'sd0); win[1] = 11'sd81; win[4] = 11'sd80; win[7] = 11'sd10;
    send(2'b10, -1, 0, 11'sd0);
    // Diagonal tie keeps
    fill(11'sd500); win[0] = 11'sd60; win[4] = 11'sd60; win[8] = 11'sd60;
    send(2'b11, -1, 0, 11'sd60);
    // Same window at 45 degrees with k2 above the centre
    win[2] = 11'sd61; win[6] = 11'sd0;
    send(2'b01, -1, 0, 11'sd0);
    // Negative centre is suppressed even when above its neighbours
    fill(-11'sd100); win[4] = -11'sd5;
    send(2'b00, -1, 0, 11'sd0);
    // Signed compare against a negative neighbour
    fill(11'sd0); win[3] = -11'sd3; win[4] = 11'sd5; win[5] = 11'sd4;
    send(2'b00, -1, 0, 11'sd5);
    idle(3);

    // Partial window, then reset mid-window
    fill(11'sd300);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      pixel_valid = 1'b1;
      gmag = win[k];
    end
    do_reset();
    fill(11'sd1); win[4] = 11'sd77;
    send(2'b10, -1, 0, 11'sd77);
    idle(2);

    // History depth: 13 kept windows 1..13
    p0 = n_pulse;
    for (int c = 1; c <= 13; c++) begin
      fill(11'sd0); win[4] = m_t'(c);
      send(2'b00, -1, 0, m_t'(c));
    end
    idle(3);
    check("depth_entry0", int'(pp[0]), 13);
    check("depth_entry11", int'(pp[11]), 2);
    check("depth_pulses", n_pulse - p0, 13);

    // Gaps mid-window with junk data on the bus
    fill(11'sd0); win[2] = 11'sd299; win[4] = 11'sd300; win[6] = 11'sd300;
    send(2'b01, 5, 3, 11'sd300);
    fill(11'sd0); win[2] = 11'sd301; win[4] = 11'sd300; win[6] = 11'sd1;
    send(2'b01, 2, 3, 11'sd0);
    idle(2);

    // Optional low threshold (LOW_THRESH = 20)
    fill(11'sd0); win[4] = 11'sd15;
`ifdef NMS_LOW_THRESH_EN
    send(2'b00, -1, 0, 11'sd0);
`else
    send(2'b00, -1, 0, 11'sd15);
`endif
    fill(11'sd0); win[4] = 11'sd20;
    send(2'b00, -1, 0, 11'sd20);
    idle(2);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("pulse_count", n_pulse, n_push);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
